// File: rtl/usr_pkg.sv
// Shared mode codes and helpers for the universal shift register.
package usr_pkg;

   localparam logic [2:0] MODE_HOLD = 3'd0;
   localparam logic [2:0] MODE_LOAD = 3'd1;
   localparam logic [2:0] MODE_SHL  = 3'd2;
   localparam logic [2:0] MODE_SHR  = 3'd3;
   localparam logic [2:0] MODE_ROL  = 3'd4;
   localparam logic [2:0] MODE_ROR  = 3'd5;
   localparam logic [2:0] MODE_ASR  = 3'd6;
   localparam logic [2:0] MODE_CLR  = 3'd7;

   // Modes that move bits and therefore advance the shift counter.
   function automatic logic is_shift_mode(input logic [2:0] m);
      return (m >= MODE_SHL) && (m <= MODE_ASR);
   endfunction

endpackage

// File: rtl/usr_next_state.sv
// Combinational next-register-value selector for the universal shift register.
module usr_next_state
   import usr_pkg::*;
#(
   parameter int         N       = 8,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic [2:0]   mode,
   input  logic [N-1:0] q_cur,
   input  logic [N-1:0] load_data,
   input  logic         sl_in,
   input  logic         sr_in,
   output logic [N-1:0] q_next
);

   // Select the next register contents for every mode code; all codes are defined.
   always_comb begin
      q_next = q_cur;
      case (mode)
         MODE_HOLD: q_next = q_cur;
         MODE_LOAD: q_next = load_data;
         MODE_SHL:  q_next = {q_cur[N-2:0], sl_in};
         MODE_SHR:  q_next = {sr_in, q_cur[N-1:1]};
         MODE_ROL:  q_next = {q_cur[N-2:0], q_cur[N-1]};
         MODE_ROR:  q_next = {q_cur[0], q_cur[N-1:1]};
         MODE_ASR:  q_next = {q_cur[N-1], q_cur[N-1:1]};
         MODE_CLR:  q_next = RST_VAL;
         default:   q_next = q_cur;
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register with enable, eight modes and a saturating
// shift counter whose done flag marks N shifts since the last load/clear.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int           N       = 8,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [2:0]   mode,
   input  logic [N-1:0] I,
   input  logic         sl_in,
   input  logic         sr_in,
   output logic [N-1:0] Q,
   output logic         so_left,
   output logic         so_right,
   output logic         done
);

   localparam int             CW      = $clog2(N + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(N);

   logic [N-1:0]  q_reg;
   logic [N-1:0]  q_mode_next;
   logic [N-1:0]  q_next;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          done_reg;
   logic          done_next;

   usr_next_state #(
      .N       (N),
      .RST_VAL (RST_VAL)
   ) u_next (
      .mode      (mode),
      .q_cur     (q_reg),
      .load_data (I),
      .sl_in     (sl_in),
      .sr_in     (sr_in),
      .q_next    (q_mode_next)
   );

   // Enable gating and shift-count bookkeeping; count saturates at N.
   always_comb begin
      q_next    = q_reg;
      cnt_next  = cnt_reg;
      done_next = done_reg;
      if (en) begin
         q_next = q_mode_next;
         if (mode == MODE_LOAD || mode == MODE_CLR) begin
            cnt_next  = '0;
            done_next = 1'b0;
         end else if (is_shift_mode(mode)) begin
            cnt_next  = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
            done_next = (cnt_next == CNT_MAX);
         end
      end
   end

   // State registers; reset overrides enable and mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_reg    <= RST_VAL;
         cnt_reg  <= '0;
         done_reg <= 1'b0;
      end else begin
         q_reg    <= q_next;
         cnt_reg  <= cnt_next;
         done_reg <= done_next;
      end
   end

   assign Q        = q_reg;
   assign so_left  = q_reg[N-1];
   assign so_right = q_reg[0];
   assign done     = done_reg;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed-vector bench for universal_shift_register (N=8, RST_VAL 00 and 5A).
module tb_universal_shift_register;
   import usr_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic [2:0] mode = MODE_HOLD;
   logic [7:0] I = 8'h00;
   logic       sl_in = 1'b0;
   logic       sr_in = 1'b0;

   logic [7:0] Q,  Q2;
   logic       so_left, so_right, done;
   logic       so_left2, so_right2, done2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   universal_shift_register #(.N(8), .RST_VAL(8'h00)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .I(I),
      .sl_in(sl_in), .sr_in(sr_in), .Q(Q), .so_left(so_left),
      .so_right(so_right), .done(done)
   );

   universal_shift_register #(.N(8), .RST_VAL(8'h5A)) dut_rv (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .I(I),
      .sl_in(sl_in), .sr_in(sr_in), .Q(Q2), .so_left(so_left2),
      .so_right(so_right2), .done(done2)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // Apply one clock of stimulus; outputs are then sampled 1 time unit after the edge.
   task automatic cyc(input logic e, input logic [2:0] m, input logic [7:0] d,
                      input logic sl, input logic sr);
      en = e; mode = m; I = d; sl_in = sl; sr_in = sr;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] shl_q  [8];
   logic       shl_so [8];
   logic [7:0] shr_q  [8];

   initial begin
      shl_q  = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
      shl_so = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      shr_q  = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

      // 1: reset overrides an enabled LOAD
      reset = 1'b1;
      cyc(1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0);
      reset = 1'b0;
      check_val("t1_reset_q", Q, 8'h00);
      check_val("t1_reset_done", done, 1'b0);
      check_val("t1_rst5a_q", Q2, 8'h5A);

      // 2: LOAD A5 then 8 left shifts with sl_in=0
      cyc(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
      check_val("t2_load_q", Q, 8'hA5);
      for (int k = 0; k < 8; k++) begin
         check_val($sformatf("t2_so_left_%0d", k), so_left, shl_so[k]);
         cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
         check_val($sformatf("t2_shl_q_%0d", k), Q, shl_q[k]);
         check_val($sformatf("t2_done_%0d", k), done, (k == 7) ? 1'b1 : 1'b0);
      end
      cyc(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
      check_val("t2_hold_done", done, 1'b1);
      check_val("t2_hold_q", Q, 8'h00);

      // 3: rotates and arithmetic shift
      cyc(1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0);
      check_val("t3_so_right", so_right, 1'b1);
      check_val("t3_load_done", done, 1'b0);
      cyc(1'b1, MODE_ROR, 8'h00, 1'b0, 1'b0);
      check_val("t3_ror", Q, 8'hC0);
      cyc(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
      check_val("t3_rol1", Q, 8'h81);
      cyc(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
      check_val("t3_rol2", Q, 8'h03);
      cyc(1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0);
      cyc(1'b1, MODE_ASR, 8'h00, 1'b0, 1'b0);
      check_val("t3_asr", Q, 8'hC0);

      // 4: enable low freezes Q and the counter
      cyc(1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      check_val("t4_pre_q", Q, 8'hE0);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0, MODE_SHL, 8'h00, 1'b1, 1'b1);
         check_val($sformatf("t4_en0_q_%0d", k), Q, 8'hE0);
      end
      for (int k = 0; k < 4; k++) cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      check_val("t4_done_after7", done, 1'b0);
      cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      check_val("t4_done_after8", done, 1'b1);
      check_val("t4_q_after8", Q, 8'h00);

      // 5: reset mid-sequence, then 8 right shifts with sr_in=1
      cyc(1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      check_val("t5_reset_q", Q, 8'h00);
      check_val("t5_reset_done", done, 1'b0);
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b1);
         check_val($sformatf("t5_shr_q_%0d", k), Q, shr_q[k]);
         check_val($sformatf("t5_done_%0d", k), done, (k == 7) ? 1'b1 : 1'b0);
      end
      cyc(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
      check_val("t5_9th_q", Q, 8'h7F);
      check_val("t5_9th_done", done, 1'b1);
      cyc(1'b1, MODE_LOAD, 8'h12, 1'b0, 1'b0);
      check_val("t5_load_q", Q, 8'h12);
      check_val("t5_load_done", done, 1'b0);
      cyc(1'b1, MODE_CLR, 8'hFF, 1'b0, 1'b0);
      check_val("t5_clr_q", Q, 8'h00);

      // 6: non-zero reset value on the second instance
      reset = 1'b1;
      cyc(1'b1, MODE_HOLD, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;
      check_val("t6_reset_q", Q2, 8'h5A);
      cyc(1'b1, MODE_LOAD, 8'h00, 1'b0, 1'b0);
      check_val("t6_load_q", Q2, 8'h00);
      for (int k = 0; k < 8; k++) cyc(1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0);
      check_val("t6_rot_done", done2, 1'b1);
      cyc(1'b1, MODE_CLR, 8'h00, 1'b0, 1'b0);
      check_val("t6_clr_q", Q2, 8'h5A);
      check_val("t6_clr_done", done2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
